ecc_139_err_collect: RTL and testbench

//  Sits directly downstream of the 139-bit ECC fault-detect stage on the FIFO read path. Registers corrected

---
 rtl/ecc_139_err_collect.sv | 199 +++++++++++++++++++
 tb/tb_ecc_139_err_collect.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_139_err_collect.sv
// ecc_139_err_collect
//   Output stage behind the 139-bit ECC fault-detect decoder on the FIFO read path.
//   It moves corrected data and an "uncorrectable" flag through a 2-entry skid buffer.
//   Both sides use a valid/ready handshake, and the order of words is strictly FIFO.
//   It also keeps the error bookkeeping for accepted words:
//     - saturating sbit/dbit/fault counters
//     - sticky status bits
//     - an sbit threshold alarm
//     - a masked, registered level interrupt
//
// Configuration macro: ECC_ERR_ADDR_CAPTURE_EN
//   When it is defined, the block captures the address tag and the flags of the first
//   error word seen since reset or the last cnt_clr.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_vld/in_rdy       upstream handshake; in_rdy is registered (= skid buffer not full)
//   in_data             corrected data word
//   in_sbit_err         per-word flag: single-bit error
//   in_dbit_err         per-word flag: double-bit error
//   in_ecc_fault        per-word flag: decoder fault
//   in_addr             read address tag (macro only)
//   out_vld/out_rdy     downstream handshake
//   out_data            registered data
//   out_uncorr          registered flag: dbit_err | ecc_fault of that word
//   cnt_clr             pulse; clears counters, sticky bits and the capture
//   irq_mask            interrupt enables {fault, dbit, sbit_thr}
//   sbit_thr            sbit alarm threshold (0 disables the alarm)
//   sbit_cnt, dbit_cnt, fault_cnt
//                       saturating error counters
//   err_sticky          {fault, dbit, sbit} seen since the last clear
//   first_err_addr      address of the first error word (macro only)
//   first_err_type      flags of the first error word (macro only)
//   irq                 registered level interrupt
module ecc_139_err_collect #(
    parameter int DATA_WIDTH = 139,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic                  in_ecc_fault,
`ifdef ECC_ERR_ADDR_CAPTURE_EN
    input  logic [ADDR_WIDTH-1:0] in_addr,
`endif
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_uncorr,
    input  logic                  cnt_clr,
    input  logic [2:0]            irq_mask,
    input  logic [CNT_WIDTH-1:0]  sbit_thr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [2:0]            err_sticky,
`ifdef ECC_ERR_ADDR_CAPTURE_EN
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [2:0]            first_err_type,
`endif
    output logic                  irq
);

    // A clear in the same cycle as an event starts the new epoch at 1.
    // The count saturates at all-ones.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic inc, input logic clr);
        if (clr)
            return {{(CNT_WIDTH-1){1'b0}}, inc};
        if (inc && (cur != {CNT_WIDTH{1'b1}}))
            return cur + 1'b1;
        return cur;
    endfunction

    logic                  accept, pop;
    logic                  vld_p1, skid_vld_p1;
    logic                  vld_p1_nxt, skid_vld_p1_nxt;
    logic                  load_from_in, load_from_skid, load_skid;
    logic [DATA_WIDTH-1:0] skid_data_p1;
    logic                  skid_uncorr_p1;
    logic                  in_uncorr;
    logic [2:0]            in_flags;
    logic                  thr_hit;

    assign accept    = in_vld & in_rdy;
    assign pop       = vld_p1 & out_rdy;
    assign in_uncorr = in_dbit_err | in_ecc_fault;
    assign in_flags  = {in_ecc_fault, in_dbit_err, in_sbit_err};
    assign out_vld   = vld_p1;

    // Occupancy is EMPTY / ONE (main) / TWO (main + skid).
    // in_rdy is low whenever the skid register is full, so accept never coincides
    // with TWO.
    always_comb begin
        vld_p1_nxt      = vld_p1;
        skid_vld_p1_nxt = skid_vld_p1;
        load_from_in    = 1'b0;
        load_from_skid  = 1'b0;
        load_skid       = 1'b0;
        if (skid_vld_p1) begin
            if (pop) begin
                load_from_skid  = 1'b1;
                skid_vld_p1_nxt = 1'b0;
            end
        end else if (accept) begin
            if (!vld_p1 || pop) begin
                load_from_in = 1'b1;
                vld_p1_nxt   = 1'b1;
            end else begin
                load_skid       = 1'b1;
                skid_vld_p1_nxt = 1'b1;
            end
        end else if (pop) begin
            vld_p1_nxt = 1'b0;
        end
    end

    // ---- stage p1: main output register + skid control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_rdy      <= 1'b0;
            out_data    <= '0;
            out_uncorr  <= 1'b0;
        end else begin
            vld_p1      <= vld_p1_nxt;
            skid_vld_p1 <= skid_vld_p1_nxt;
            in_rdy      <= ~skid_vld_p1_nxt;
            if (load_from_in) begin
                out_data   <= in_data;
                out_uncorr <= in_uncorr;
            end else if (load_from_skid) begin
                out_data   <= skid_data_p1;
                out_uncorr <= skid_uncorr_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_p1   <= in_data;
            skid_uncorr_p1 <= in_uncorr;
        end
    end

    // ---- error bookkeeping ----
    // irq is computed from the registered counters and sticky bits. It therefore
    // lags its cause by one cycle and falls one cycle after a clear or a mask drop.
    assign thr_hit = (sbit_thr != '0) && (sbit_cnt >= sbit_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_cnt   <= '0;
            dbit_cnt   <= '0;
            fault_cnt  <= '0;
            err_sticky <= 3'b000;
            irq        <= 1'b0;
        end else begin
            sbit_cnt   <= cnt_next(sbit_cnt,  accept & in_sbit_err,  cnt_clr);
            dbit_cnt   <= cnt_next(dbit_cnt,  accept & in_dbit_err,  cnt_clr);
            fault_cnt  <= cnt_next(fault_cnt, accept & in_ecc_fault, cnt_clr);
            err_sticky <= (cnt_clr ? 3'b000 : err_sticky) | (accept ? in_flags : 3'b000);
            irq        <= (irq_mask[2] & err_sticky[2]) | (irq_mask[1] & err_sticky[1]) |
                          (irq_mask[0] & thr_hit);
        end
    end

`ifdef ECC_ERR_ADDR_CAPTURE_EN
    logic cap_vld;
    logic any_err;

    assign any_err = accept & (|in_flags);

    // A clear in the same cycle as an error re-arms the capture and takes that
    // error word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld        <= 1'b0;
            first_err_addr <= '0;
            first_err_type <= 3'b000;
        end else if (any_err && (cnt_clr || !cap_vld)) begin
            cap_vld        <= 1'b1;
            first_err_addr <= in_addr;
            first_err_type <= in_flags;
        end else if (cnt_clr) begin
            cap_vld        <= 1'b0;
            first_err_addr <= '0;
            first_err_type <= 3'b000;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_139_err_collect.sv
// Testbench for ecc_139_err_collect.
// Two instances share the same stimulus: the default one (16-bit counters) and one
// with 4-bit counters that exercises saturation. A queue-based reference model
// predicts every output, and a negedge process compares the DUT against it on every
// cycle.
module tb_ecc_139_err_collect;
    localparam int DW = 139;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sbit_err = 1'b0, in_dbit_err = 1'b0, in_ecc_fault = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          out_rdy = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [2:0]    irq_mask = 3'b000;
    logic [15:0]   sbit_thr = '0;

    logic          in_rdy, out_vld, out_uncorr, irq;
    logic [DW-1:0] out_data;
    logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;
    logic [2:0]    err_sticky;
    logic          in_rdy4, out_vld4, out_uncorr4, irq4;
    logic [DW-1:0] out_data4;
    logic [3:0]    sbit_cnt4, dbit_cnt4, fault_cnt4;
    logic [2:0]    err_sticky4;
`ifdef ECC_ERR_ADDR_CAPTURE_EN
    logic [AW-1:0] first_err_addr, first_err_addr4;
    logic [2:0]    first_err_type, first_err_type4;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ecc_139_err_collect u16 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_ecc_fault(in_ecc_fault),
`ifdef ECC_ERR_ADDR_CAPTURE_EN
        .in_addr(in_addr),
`endif
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_uncorr(out_uncorr),
        .cnt_clr(cnt_clr), .irq_mask(irq_mask), .sbit_thr(sbit_thr),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .err_sticky(err_sticky),
`ifdef ECC_ERR_ADDR_CAPTURE_EN
        .first_err_addr(first_err_addr), .first_err_type(first_err_type),
`endif
        .irq(irq)
    );

    ecc_139_err_collect #(.CNT_WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy4), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_ecc_fault(in_ecc_fault),
`ifdef ECC_ERR_ADDR_CAPTURE_EN
        .in_addr(in_addr),
`endif
        .out_vld(out_vld4), .out_rdy(out_rdy), .out_data(out_data4), .out_uncorr(out_uncorr4),
        .cnt_clr(cnt_clr), .irq_mask(irq_mask), .sbit_thr(sbit_thr[3:0]),
        .sbit_cnt(sbit_cnt4), .dbit_cnt(dbit_cnt4), .fault_cnt(fault_cnt4), .err_sticky(err_sticky4),
`ifdef ECC_ERR_ADDR_CAPTURE_EN
        .first_err_addr(first_err_addr4), .first_err_type(first_err_type4),
`endif
        .irq(irq4)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW:0] q[$];          // {data, uncorr} in arrival order
    bit          m_rdy;
    int          ms[2], md[2], mf[2];
    int          mmax[2] = '{65535, 15};
    bit [2:0]    m_st;
    bit          m_irq[2];
    bit          m_cap_vld;
    int          m_addr;
    bit [2:0]    m_type;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_rdy = 0; m_st = 0; m_cap_vld = 0; m_addr = 0; m_type = 0;
            for (int k = 0; k < 2; k++) begin
                ms[k] = 0; md[k] = 0; mf[k] = 0; m_irq[k] = 0;
            end
        end else begin
            bit acc, pop;
            bit [2:0] fl;
            acc = in_vld && m_rdy;
            pop = (q.size() > 0) && out_rdy;
            fl  = {in_ecc_fault, in_dbit_err, in_sbit_err};
            for (int k = 0; k < 2; k++) begin
                int thr;
                thr = (k == 0) ? int'(sbit_thr) : int'(sbit_thr[3:0]);
                m_irq[k] = (irq_mask[2] && m_st[2]) || (irq_mask[1] && m_st[1]) ||
                           (irq_mask[0] && thr != 0 && ms[k] >= thr);
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({in_data, in_dbit_err | in_ecc_fault});
            for (int k = 0; k < 2; k++) begin
                if (cnt_clr) begin
                    ms[k] = 0; md[k] = 0; mf[k] = 0;
                end
                if (acc && fl[0] && ms[k] < mmax[k]) ms[k]++;
                if (acc && fl[1] && md[k] < mmax[k]) md[k]++;
                if (acc && fl[2] && mf[k] < mmax[k]) mf[k]++;
            end
            if (cnt_clr) m_st = 0;
            if (acc) m_st = m_st | fl;
            if (acc && fl != 0 && (cnt_clr || !m_cap_vld)) begin
                m_cap_vld = 1; m_addr = int'(in_addr); m_type = fl;
            end else if (cnt_clr) begin
                m_cap_vld = 0; m_addr = 0; m_type = 0;
            end
            m_rdy = q.size() < 2;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_rdy", in_rdy, 0);
            chk("rst_out_vld", out_vld, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, sbit_cnt4, dbit_cnt4, fault_cnt4}, 0);
            chk("rst_irq_sticky", {irq, irq4, err_sticky}, 0);
        end else begin
            chk("in_rdy", in_rdy, m_rdy);
            chk("out_vld", out_vld, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0][DW:1]);
                chk("out_uncorr", out_uncorr, q[0][0]);
            end
            chk("sbit_cnt", sbit_cnt, ms[0]);
            chk("dbit_cnt", dbit_cnt, md[0]);
            chk("fault_cnt", fault_cnt, mf[0]);
            chk("sbit_cnt4", sbit_cnt4, ms[1]);
            chk("dbit_cnt4", dbit_cnt4, md[1]);
            chk("fault_cnt4", fault_cnt4, mf[1]);
            chk("err_sticky", err_sticky, m_st);
            chk("err_sticky4", err_sticky4, m_st);
            chk("irq", irq, m_irq[0]);
            chk("irq4", irq4, m_irq[1]);
`ifdef ECC_ERR_ADDR_CAPTURE_EN
            chk("first_err_addr", first_err_addr, m_addr);
            chk("first_err_type", first_err_type, m_type);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit s, input bit d, input bit f, input bit c,
                        input int a);
        logic [159:0] r;
        @(negedge clk);
        #1;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_vld = v; in_sbit_err = s; in_dbit_err = d; in_ecc_fault = f; cnt_clr = c;
        in_data = r[DW-1:0];
        in_addr = a[AW-1:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // 8 clean words at full throughput
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        idle(3);
        chk("t1_counts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        chk("t1_irq", irq, 0);

        // downstream stall for 3 cycles under a continuous stream
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        out_rdy = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_in_rdy_low", in_rdy, 0);
        chk("t2_out_vld_held", out_vld, 1);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle(4);

        // sbit threshold alarm
        sbit_thr = 16'd5; irq_mask = 3'b001;
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_sbit5", sbit_cnt, 5);
        chk("t3_irq_not_yet", irq, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_irq_set", irq, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_cleared", sbit_cnt, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_irq_fall", irq, 0);

        // dbit + fault on one word
        irq_mask = 3'b000;
        step(1, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_uncorr", out_uncorr, 1);
        chk("t4_counts", {dbit_cnt, fault_cnt, err_sticky}, {16'd1, 16'd1, 3'b110});

        // saturation of the 4-bit counter, then clear + event in the same cycle
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
        idle(2);
        chk("t5_sat4", sbit_cnt4, 15);
        chk("t5_cnt16", sbit_cnt, 20);
        step(1, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_clr_evt4", sbit_cnt4, 1);
        chk("t5_clr_evt16", {sbit_cnt, err_sticky}, {16'd1, 3'b001});

`ifdef ECC_ERR_ADDR_CAPTURE_EN
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 'h12);
        step(1, 0, 1, 0, 0, 'h34);
        idle(2);
        chk("t6_first", {first_err_addr, first_err_type}, {10'h12, 3'b001});
        step(1, 0, 0, 1, 1, 'h56);
        idle(1);
        chk("t6_reclr", {first_err_addr, first_err_type}, {10'h56, 3'b100});
`endif

        // randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            if (i % 50 == 0) begin
                irq_mask = 3'($urandom);
                sbit_thr = 16'($urandom_range(0, 6));
            end
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0, int'($urandom_range(0, 1023)));
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_out_vld", out_vld, 0);
                chk("async_in_rdy", in_rdy, 0);
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
